// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: two requesters share one register-bank write port, with an
// optional per-register pending-write scoreboard enabled by `define REG_SCOREBOARD_EN.
module reg_wb_arbiter #(
  parameter int FIXED_PRI = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_aw,
  input  logic [31:0] a_din,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_aw,
  input  logic [31:0] b_din,
  output logic        b_ready,
  input  logic        hold,
  output logic        reg_write,
  output logic [4:0]  aw,
  output logic [31:0] din,
  input  logic        issue_valid,
  input  logic [4:0]  issue_aw,
  output logic        issue_ready,
  input  logic [4:0]  ar1,
  input  logic [4:0]  ar2,
  output logic        stall,
  output logic [31:0] busy
);

  typedef enum logic {LAST_A, LAST_B} last_t;

  last_t       state_q, state_d;
  logic        gnt;
  logic [4:0]  gnt_aw;
  logic [31:0] gnt_din;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LAST_B;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (a_ready)      state_d = LAST_A;
    else if (b_ready) state_d = LAST_B;
  end

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n && !hold) begin
      if (FIXED_PRI != 0) begin
        a_ready = a_valid;
        b_ready = b_valid & ~a_valid;
      end else if (a_valid && b_valid) begin
        a_ready = (state_q == LAST_B);
        b_ready = (state_q == LAST_A);
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign gnt     = a_ready | b_ready;
  assign gnt_aw  = a_ready ? a_aw  : b_aw;
  assign gnt_din = a_ready ? a_din : b_din;

  // Register 0 is hardwired, so its handshake completes without a bank write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      aw        <= 5'd0;
      din       <= 32'd0;
    end else begin
      reg_write <= gnt && (gnt_aw != 5'd0);
      if (gnt) begin
        aw  <= gnt_aw;
        din <= gnt_din;
      end
    end
  end

`ifdef REG_SCOREBOARD_EN
  logic [1:0] count_q [32];
  logic       issue_inc;
  logic       commit_dec;

  assign issue_ready = rst_n && (count_q[issue_aw] != 2'd3);
  assign issue_inc   = issue_valid && issue_ready && (issue_aw != 5'd0);
  assign commit_dec  = gnt && (gnt_aw != 5'd0);

  // A simultaneous issue and commit to one register cancel; commits never underflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) count_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if ((issue_inc && issue_aw == 5'(i)) &&
            !(commit_dec && gnt_aw == 5'(i) && count_q[i] != 2'd0))
          count_q[i] <= count_q[i] + 2'd1;
        else if (!(issue_inc && issue_aw == 5'(i)) &&
                 (commit_dec && gnt_aw == 5'(i) && count_q[i] != 2'd0))
          count_q[i] <= count_q[i] - 2'd1;
      end
    end
  end

  always_comb begin
    busy = 32'd0;
    for (int i = 0; i < 32; i++) busy[i] = (count_q[i] != 2'd0);
  end

  assign stall = ((ar1 != 5'd0) && busy[ar1]) ||
                 ((ar2 != 5'd0) && busy[ar2]) ||
                 (issue_valid && !issue_ready);
`else
  logic unused_sb;

  assign unused_sb   = ^{issue_valid, issue_aw, ar1, ar2};
  assign issue_ready = rst_n;
  assign stall       = 1'b0;
  assign busy        = 32'd0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; scoreboard checks follow REG_SCOREBOARD_EN.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, hold, issue_valid;
  logic [4:0]  a_aw, b_aw, issue_aw, ar1, ar2;
  logic [31:0] a_din, b_din;

  logic        a_ready, b_ready, reg_write, issue_ready, stall;
  logic [4:0]  aw;
  logic [31:0] din, busy;

  logic        fp_a_ready, fp_b_ready, fp_reg_write, fp_issue_ready, fp_stall;
  logic [4:0]  fp_aw;
  logic [31:0] fp_din, fp_busy;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.FIXED_PRI(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_aw(a_aw), .a_din(a_din), .a_ready(a_ready),
    .b_valid(b_valid), .b_aw(b_aw), .b_din(b_din), .b_ready(b_ready),
    .hold(hold), .reg_write(reg_write), .aw(aw), .din(din),
    .issue_valid(issue_valid), .issue_aw(issue_aw), .issue_ready(issue_ready),
    .ar1(ar1), .ar2(ar2), .stall(stall), .busy(busy)
  );

  reg_wb_arbiter #(.FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_aw(a_aw), .a_din(a_din), .a_ready(fp_a_ready),
    .b_valid(b_valid), .b_aw(b_aw), .b_din(b_din), .b_ready(fp_b_ready),
    .hold(hold), .reg_write(fp_reg_write), .aw(fp_aw), .din(fp_din),
    .issue_valid(issue_valid), .issue_aw(issue_aw), .issue_ready(fp_issue_ready),
    .ar1(ar1), .ar2(ar2), .stall(fp_stall), .busy(fp_busy)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    else checks_passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_stimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_aw = aa; a_din = ad;
    b_valid = bv; b_aw = ba; b_din = bd;
  endtask

  logic exp_a [4];

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    issue_valid = 1'b0; issue_aw = 5'd0; ar1 = 5'd0; ar2 = 5'd0;
    apply_stimulus(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);

    settle();
    check_output("rst_a_ready", a_ready, 0);
    check_output("rst_b_ready", b_ready, 0);
    check_output("rst_fp_a_ready", fp_a_ready, 0);
    tick(); tick();
    check_output("rst_reg_write", reg_write, 0);
    check_output("rst_aw", aw, 0);
    check_output("rst_din", din, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_issue_ready", issue_ready, 0);

    rst_n = 1'b1;
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    settle();
    check_output("post_rst_busy", busy, 0);
    check_output("post_rst_stall", stall, 0);
    check_output("post_rst_issue_ready", issue_ready, 1);

    // Both valid for four cycles: round-robin alternates starting with A.
    exp_a[0] = 1; exp_a[1] = 0; exp_a[2] = 1; exp_a[3] = 0;
    apply_stimulus(1, 5'd1, 32'hA, 1, 5'd2, 32'hB);
    for (int k = 0; k < 4; k++) begin
      settle();
      check_output($sformatf("rr_a_ready%0d", k), a_ready, exp_a[k]);
      check_output($sformatf("rr_b_ready%0d", k), b_ready, !exp_a[k]);
      check_output($sformatf("fp_a_ready%0d", k), fp_a_ready, 1);
      check_output($sformatf("fp_b_ready%0d", k), fp_b_ready, 0);
      tick();
      check_output($sformatf("rr_aw%0d", k), aw, exp_a[k] ? 5'd1 : 5'd2);
      check_output($sformatf("rr_din%0d", k), din, exp_a[k] ? 32'hA : 32'hB);
      check_output($sformatf("fp_aw%0d", k), fp_aw, 1);
    end
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tick();
    check_output("idle_reg_write", reg_write, 0);

    // Single A request to r5.
    apply_stimulus(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0);
    settle();
    check_output("a_only_a_ready", a_ready, 1);
    check_output("a_only_b_ready", b_ready, 0);
    tick();
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check_output("a_only_reg_write", reg_write, 1);
    check_output("a_only_aw", aw, 5);
    check_output("a_only_din", din, 32'h1234);
    tick();
    check_output("a_only_after_reg_write", reg_write, 0);

    // Write to r0 handshakes but never strobes the bank.
    apply_stimulus(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0);
    settle();
    check_output("r0_a_ready", a_ready, 1);
    tick();
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check_output("r0_reg_write", reg_write, 0);

    apply_stimulus(0, 5'd0, 32'h0, 1, 5'd9, 32'h99);
    settle();
    check_output("b_only_b_ready", b_ready, 1);
    check_output("b_only_a_ready", a_ready, 0);
    check_output("b_only_fp_b_ready", fp_b_ready, 1);
    tick();
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check_output("b_only_reg_write", reg_write, 1);
    check_output("b_only_aw", aw, 9);
    check_output("b_only_din", din, 32'h99);

    // Back-to-back writes to r4 land in grant order.
    apply_stimulus(1, 5'd4, 32'h1, 0, 5'd0, 32'h0);
    tick();
    check_output("order1_din", din, 32'h1);
    apply_stimulus(0, 5'd0, 32'h0, 1, 5'd4, 32'h2);
    tick();
    check_output("order2_aw", aw, 4);
    check_output("order2_din", din, 32'h2);

    hold = 1'b1;
    apply_stimulus(1, 5'd6, 32'h6, 1, 5'd8, 32'h8);
    settle();
    check_output("hold_a_ready", a_ready, 0);
    check_output("hold_b_ready", b_ready, 0);
    check_output("hold_fp_a_ready", fp_a_ready, 0);
    tick();
    check_output("hold_reg_write", reg_write, 0);
    check_output("hold_fp_reg_write", fp_reg_write, 0);
    hold = 1'b0;
    settle();
    check_output("unhold_a_ready", a_ready, 1);
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

`ifdef REG_SCOREBOARD_EN
    issue_valid = 1'b1; issue_aw = 5'd7;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_output($sformatf("sb_issue_ready%0d", k), issue_ready, 1);
      tick();
    end
    settle();
    check_output("sb_busy7", busy, 32'h80);
    check_output("sb_sat_ready", issue_ready, 0);
    check_output("sb_sat_stall", stall, 1);
    tick();
    issue_valid = 1'b0; ar1 = 5'd7;
    settle();
    check_output("sb_ar1_stall", stall, 1);
    ar1 = 5'd0; ar2 = 5'd7;
    settle();
    check_output("sb_ar2_stall", stall, 1);
    ar2 = 5'd0;
    settle();
    check_output("sb_no_stall", stall, 0);
    apply_stimulus(1, 5'd7, 32'h7, 0, 5'd0, 32'h0);
    tick(); tick();
    check_output("sb_two_commits", busy, 32'h80);
    ar1 = 5'd7;
    tick();
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    settle();
    check_output("sb_three_commits", busy, 0);
    check_output("sb_commit_stall", stall, 0);
    ar1 = 5'd0;

    issue_valid = 1'b1; issue_aw = 5'd3;
    tick();
    apply_stimulus(1, 5'd3, 32'h3, 0, 5'd0, 32'h0);
    tick();
    issue_valid = 1'b0;
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    settle();
    check_output("sb_same_edge", busy, 32'h8);
    apply_stimulus(1, 5'd3, 32'h3, 0, 5'd0, 32'h0);
    tick();
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check_output("sb_same_edge_drain", busy, 0);

    apply_stimulus(1, 5'd5, 32'h5, 0, 5'd0, 32'h0);
    tick();
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    issue_valid = 1'b1; issue_aw = 5'd5;
    tick();
    issue_valid = 1'b0;
    check_output("sb_no_underflow", busy, 32'h20);
    apply_stimulus(1, 5'd5, 32'h5, 0, 5'd0, 32'h0);
    tick();
    apply_stimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check_output("sb_underflow_drain", busy, 0);

    issue_valid = 1'b1; issue_aw = 5'd0;
    settle();
    check_output("sb_r0_issue_ready", issue_ready, 1);
    tick();
    check_output("sb_r0_busy", busy, 0);
    issue_aw = 5'd10;
    tick();
    issue_valid = 1'b0;
    check_output("sb_busy10", busy, 32'h400);
`else
    issue_valid = 1'b1; issue_aw = 5'd7; ar1 = 5'd7; ar2 = 5'd3;
    settle();
    check_output("nosb_issue_ready", issue_ready, 1);
    check_output("nosb_stall", stall, 0);
    tick();
    check_output("nosb_busy", busy, 0);
    check_output("nosb_stall_after", stall, 0);
    issue_valid = 1'b0; ar1 = 5'd0; ar2 = 5'd0;
`endif

    // Leave the arbiter in LAST_A, then reset mid-stream with both requesting.
    apply_stimulus(1, 5'd1, 32'h11, 0, 5'd0, 32'h0);
    tick();
    apply_stimulus(1, 5'd12, 32'hC, 1, 5'd13, 32'hD);
    rst_n = 1'b0;
    settle();
    check_output("mid_rst_a_ready", a_ready, 0);
    check_output("mid_rst_b_ready", b_ready, 0);
    check_output("mid_rst_issue_ready", issue_ready, 0);
    tick();
    check_output("mid_rst_reg_write", reg_write, 0);
    check_output("mid_rst_aw", aw, 0);
    check_output("mid_rst_din", din, 0);
    check_output("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    settle();
    check_output("rel_a_ready", a_ready, 1);
    check_output("rel_b_ready", b_ready, 0);
    tick();
    check_output("rel_aw", aw, 12);
    check_output("rel_reg_write", reg_write, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
